sat_counter_ctrl: RTL and testbench
===================================

# sat_counter_ctrl

Parametrised saturating up/down counter driven by two raw push-buttons, with per-button debounce, optional hold-to-repeat, and limit indicator LEDs. It supersedes the fixed 16-bit debounce/saturation/LED chain: width, step, limits and debounce time are generic. It also adds clear, clip-event reporting and auto-repeat. It sits directly behind the board buttons and feeds the LED pins and any consumer of the counter value.

## Interface
- WIDTH, 16: counter width in bits.
- STEP, 1: increment/decrement amount per accepted press; 1 ≤ STEP ≤ MAX_VAL−MIN_VAL.
- MIN_VAL, 0: lower saturation limit.
- MAX_VAL, 2**WIDTH−1: upper saturation limit; MIN_VAL < MAX_VAL.
- DEB_CYCLES, 50000: consecutive stable cycles required to accept a button level change; ≥ 2.
- REPEAT_DELAY, 25000000: hold cycles before the first auto-repeat step (only with AUTOREPEAT_EN).
- REPEAT_PERIOD, 5000000: cycles between subsequent auto-repeat steps (only with AUTOREPEAT_EN).
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- btn_inc  in  1  raw increment button, active-high, asynchronous to clk.
- btn_dec  in  1  raw decrement button, active-high, asynchronous to clk.
- clr  in  1  synchronous clear; loads MIN_VAL.
- value  out  WIDTH  current counter value.
- at_max  out  1  value == MAX_VAL.
- at_min  out  1  value == MIN_VAL.
- clip  out  1  one-cycle pulse when a step was limited by saturation.
- led_r  out  1  equals at_max.
- led_g  out  1  equals at_min.

## Operation
- Reset values: value = MIN_VAL, at_min = 1, at_max = 0, clip = 0, led_g = 1, led_r = 0, all debounce/repeat state idle, stable button levels = 0.
- Each button: 2-FF synchroniser, then a debounce counter. The stable level toggles once the synchronised input has differed from it for DEB_CYCLES consecutive cycles; any agreeing sample zeroes the counter. A rising edge of the stable level yields a one-cycle step request. Falling edges yield nothing.
- Step arithmetic is done at WIDTH+1 bits.
  - inc: value ← min(value+STEP, MAX_VAL).
  - dec: value ← max(value−STEP, MIN_VAL), computed without wrap.
- clip pulses when the unclamped result exceeds the limit. This includes a request made while already at the limit: value stays unchanged and clip = 1.
- Priority per cycle: clr > (inc and dec both requested → no change, clip = 0) > single request.
- at_max, at_min, led_r and led_g are registered. They are consistent with value in the same cycle.
- rst asserted mid-debounce or mid-repeat aborts everything and returns to the reset values.

## Timing
- Raw button edge (held clean) to value update: DEB_CYCLES + 3 rising edges. That is 2 synchroniser stages, DEB_CYCLES of debounce, and 1 register.
- clr: value = MIN_VAL on the edge after clr is sampled high.
- clip is asserted in the same cycle as the value update it describes.
- Auto-repeat FSM per button, states IDLE → HOLD → REPEAT:
  - IDLE → HOLD on a step request.
  - HOLD → REPEAT after REPEAT_DELAY cycles of the stable level held high; one extra request is issued on entry.
  - REPEAT issues one request every REPEAT_PERIOD cycles.
  - Any state → IDLE when the stable level goes low.
- clr does not reset the FSMs; repeats continue from MIN_VAL.

## Configuration
- AUTOREPEAT_EN defined: the repeat FSMs are built, and a held button produces repeated steps as above.
- AUTOREPEAT_EN undefined: no FSM. Exactly one step per press regardless of hold time. REPEAT_DELAY and REPEAT_PERIOD are ignored.

## Structure
- Package sat_pkg holds:
  - the repeat-state enum (IDLE, HOLD, REPEAT);
  - a function for the clog2-sized counter widths used by debounce and repeat;
  - the step-request struct (inc, dec).
- Sub-module btn_conditioner, instantiated twice, contains the synchroniser, the debounce counter, edge detect, and the optional repeat FSM. It is parameterised by DEB_CYCLES, REPEAT_DELAY and REPEAT_PERIOD, and outputs a one-cycle step request.
- The top holds the saturating arithmetic, clr, the flags and the LED mapping.

## Test plan
Use WIDTH=4, STEP=3, MIN_VAL=2, MAX_VAL=13, DEB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5 unless noted.
- Reset: rst pulse → value=2, at_min=led_g=1, at_max=led_r=0, clip=0.
- Press btn_inc clean for 10 cycles → value becomes 5 exactly 7 edges after the press; one step only.
- Five clean inc presses from 2 → value 5, 8, 11, 13 (clip=1 on that step), then 13 again with clip=1; at_max=led_r=1.
- Bounce btn_dec high/low every 2 cycles for 20 cycles, then release → value unchanged, no clip.
- Both buttons pressed in identical cycles → value unchanged. Then clr while value=8 → value=2 next edge, at_min=1.
- With AUTOREPEAT_EN: hold btn_inc from 2 → steps at debounce+3, +20, +25, +30 … reaching 5, 8, 11, 13, then held at 13 with clip pulses. Without AUTOREPEAT_EN, the same hold gives only 5.

Source files
------------

// File: rtl/sat_pkg.sv
// Shared types and helpers for the saturating push-button counter.
package sat_pkg;

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} rpt_state_t;

  typedef struct packed {
    logic inc;
    logic dec;
  } step_req_t;

  // Bits needed for a counter that runs 0 .. n-1.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sat_counter_ctrl_btn_conditioner.sv
// Button conditioner: 2-FF synchroniser, debounce, rising-edge request and,
// when AUTOREPEAT_EN is defined, a hold-to-repeat FSM.
module btn_conditioner
  import sat_pkg::*;
#(
  parameter int DEB_CYCLES    = 50000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic req
);

  localparam int DW = cnt_width(DEB_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          stable_reg;
  logic          stable_d_reg;
  logic [DW-1:0] deb_cnt_reg;
  logic          press;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg    <= 1'b0;
      sync2_reg    <= 1'b0;
      stable_reg   <= 1'b0;
      stable_d_reg <= 1'b0;
      deb_cnt_reg  <= '0;
    end else begin
      sync1_reg    <= btn;
      sync2_reg    <= sync1_reg;
      stable_d_reg <= stable_reg;
      // Any sample agreeing with the stable level restarts the count.
      if (sync2_reg != stable_reg) begin
        if (deb_cnt_reg == DEB_LAST) begin
          stable_reg  <= ~stable_reg;
          deb_cnt_reg <= '0;
        end else begin
          deb_cnt_reg <= deb_cnt_reg + 1'b1;
        end
      end else begin
        deb_cnt_reg <= '0;
      end
    end
  end

  assign press = stable_reg & ~stable_d_reg;

`ifdef AUTOREPEAT_EN
  localparam int RW = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  rpt_state_t    state_reg;
  rpt_state_t    state_next;
  logic [RW-1:0] rpt_cnt_reg;
  logic [RW-1:0] rpt_cnt_next;
  logic          rpt_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      rpt_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      rpt_cnt_reg <= rpt_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    rpt_cnt_next = rpt_cnt_reg;
    rpt_req      = 1'b0;
    if (!stable_reg) begin
      state_next   = IDLE;
      rpt_cnt_next = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (press) begin
            state_next   = HOLD;
            rpt_cnt_next = '0;
          end
        end
        HOLD: begin
          if (rpt_cnt_reg == DELAY_LAST) begin
            state_next   = REPEAT;
            rpt_cnt_next = '0;
            rpt_req      = 1'b1;
          end else begin
            rpt_cnt_next = rpt_cnt_reg + 1'b1;
          end
        end
        REPEAT: begin
          if (rpt_cnt_reg == PERIOD_LAST) begin
            rpt_cnt_next = '0;
            rpt_req      = 1'b1;
          end else begin
            rpt_cnt_next = rpt_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_next   = IDLE;
          rpt_cnt_next = '0;
        end
      endcase
    end
  end

  assign req = press | rpt_req;
`else
  localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_PERIOD;
  assign req = press;
`endif

endmodule

// File: rtl/sat_counter_ctrl.sv
// Saturating up/down counter behind two debounced buttons, with clear,
// clip pulse and limit LEDs. Define AUTOREPEAT_EN for hold-to-repeat.
module sat_counter_ctrl
  import sat_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int STEP          = 1,
  parameter int MIN_VAL       = 0,
  parameter int MAX_VAL       = 2**WIDTH - 1,
  parameter int DEB_CYCLES    = 50000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_inc,
  input  logic             btn_dec,
  input  logic             clr,
  output logic [WIDTH-1:0] value,
  output logic             at_max,
  output logic             at_min,
  output logic             clip,
  output logic             led_r,
  output logic             led_g
);

  localparam logic [WIDTH:0]   STEP_W    = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]   MAX_W     = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   DEC_FLOOR = (WIDTH+1)'(MIN_VAL + STEP);
  localparam logic [WIDTH-1:0] MIN_V     = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_V     = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] STEP_V    = WIDTH'(STEP);

  logic             inc_req;
  logic             dec_req;
  step_req_t        req;
  logic [WIDTH-1:0] value_reg;
  logic [WIDTH-1:0] value_next;
  logic             clip_reg;
  logic             clip_next;
  logic             at_max_reg;
  logic             at_min_reg;
  logic [WIDTH:0]   sum;

  btn_conditioner #(
    .DEB_CYCLES   (DEB_CYCLES),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_inc (
    .clk(clk),
    .rst(rst),
    .btn(btn_inc),
    .req(inc_req)
  );

  btn_conditioner #(
    .DEB_CYCLES   (DEB_CYCLES),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_dec (
    .clk(clk),
    .rst(rst),
    .btn(btn_dec),
    .req(dec_req)
  );

  assign req = '{inc: inc_req, dec: dec_req};
  assign sum = {1'b0, value_reg} + STEP_W;

  // Decrement clamps before subtracting so the result never wraps.
  always_comb begin
    value_next = value_reg;
    clip_next  = 1'b0;
    if (clr) begin
      value_next = MIN_V;
    end else if (req.inc && !req.dec) begin
      if (sum > MAX_W) begin
        value_next = MAX_V;
        clip_next  = 1'b1;
      end else begin
        value_next = sum[WIDTH-1:0];
      end
    end else if (req.dec && !req.inc) begin
      if ({1'b0, value_reg} < DEC_FLOOR) begin
        value_next = MIN_V;
        clip_next  = 1'b1;
      end else begin
        value_next = value_reg - STEP_V;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_reg  <= MIN_V;
      clip_reg   <= 1'b0;
      at_max_reg <= 1'b0;
      at_min_reg <= 1'b1;
    end else begin
      value_reg  <= value_next;
      clip_reg   <= clip_next;
      at_max_reg <= (value_next == MAX_V);
      at_min_reg <= (value_next == MIN_V);
    end
  end

  assign value  = value_reg;
  assign clip   = clip_reg;
  assign at_max = at_max_reg;
  assign at_min = at_min_reg;
  assign led_r  = at_max_reg;
  assign led_g  = at_min_reg;

endmodule

// File: tb/tb_sat_counter_ctrl.sv
// Scoreboard bench for sat_counter_ctrl (WIDTH=4, STEP=3, limits 2..13, DEB_CYCLES=4).
module tb_sat_counter_ctrl;

  localparam int MINV = 2;
  localparam int MAXV = 13;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_inc = 1'b0;
  logic       btn_dec = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] value;
  logic       at_max, at_min, clip, led_r, led_g;

  int cyc = 0;
  int total = 0;
  int passed = 0;

  typedef struct {
    int v;
    bit c;
    int cyc;
  } exp_t;

  exp_t q[$];

  sat_counter_ctrl #(
    .WIDTH(4), .STEP(3), .MIN_VAL(MINV), .MAX_VAL(MAXV),
    .DEB_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
  ) dut (
    .clk(clk), .rst(rst), .btn_inc(btn_inc), .btn_dec(btn_dec), .clr(clr),
    .value(value), .at_max(at_max), .at_min(at_min), .clip(clip),
    .led_r(led_r), .led_g(led_g)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endfunction

  task automatic push(input int v, input bit c, input int at_cyc);
    exp_t e;
    e.v = v;
    e.c = c;
    e.cyc = at_cyc;
    q.push_back(e);
  endtask

  // Drives the buttons from the current negedge, holds, releases, then settles.
  task automatic press(input logic i, input logic d, input int hold);
    btn_inc = i;
    btn_dec = d;
    repeat (hold) @(negedge clk);
    btn_inc = 1'b0;
    btn_dec = 1'b0;
    repeat (14) @(negedge clk);
  endtask

  task automatic step(input logic i, input logic d, input int v, input bit c);
    @(negedge clk);
    push(v, c, cyc + 7);
    press(i, d, 10);
  endtask

  task automatic do_clr();
    @(negedge clk);
    push(MINV, 1'b0, cyc + 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Monitor: an output event is a reset release, a value change or a clip pulse.
  initial begin
    logic [3:0] prev_v;
    bit was_rst;
    exp_t e;
    prev_v = '0;
    was_rst = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        was_rst = 1'b1;
        prev_v = value;
      end else begin
        if (was_rst || value != prev_v || clip) begin
          if (q.size() == 0) begin
            total++;
            $display("FAIL unexpected_event: value=%0d clip=%0b at cycle %0d, expected no output change",
                     value, clip, cyc);
          end else begin
            e = q.pop_front();
            chk("value", int'(value), e.v);
            chk("clip", int'(clip), int'(e.c));
            chk("at_max", int'(at_max), int'(e.v == MAXV));
            chk("at_min", int'(at_min), int'(e.v == MINV));
            chk("led_r", int'(led_r), int'(e.v == MAXV));
            chk("led_g", int'(led_g), int'(e.v == MINV));
            if (e.cyc >= 0) chk("cycle", cyc, e.cyc);
          end
        end
        was_rst = 1'b0;
        prev_v = value;
      end
    end
  end

  initial begin
    exp_t e;
    int c0;
    repeat (3) @(negedge clk);
    push(MINV, 1'b0, -1);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    step(1'b1, 1'b0, 5, 1'b0);
    step(1'b1, 1'b0, 8, 1'b0);
    step(1'b1, 1'b0, 11, 1'b0);
    step(1'b1, 1'b0, 13, 1'b1);
    step(1'b1, 1'b0, 13, 1'b1);

    // Bouncing dec never stays stable for DEB_CYCLES: no event expected.
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      btn_dec = ~btn_dec;
      repeat (2) @(negedge clk);
    end
    btn_dec = 1'b0;
    repeat (14) @(negedge clk);

    @(negedge clk);
    press(1'b1, 1'b1, 10);
    do_clr();

    step(1'b1, 1'b0, 5, 1'b0);
    step(1'b0, 1'b1, 2, 1'b0);
    step(1'b0, 1'b1, 2, 1'b1);
    step(1'b1, 1'b0, 5, 1'b0);
    step(1'b1, 1'b0, 8, 1'b0);
    @(negedge clk);
    press(1'b1, 1'b1, 10);
    do_clr();

    // Long hold of btn_inc from MIN_VAL.
    @(negedge clk);
    c0 = cyc;
    push(5, 1'b0, c0 + 7);
`ifdef AUTOREPEAT_EN
    push(8, 1'b0, c0 + 27);
    push(11, 1'b0, c0 + 32);
    for (int k = 0; k < 5; k++) push(13, 1'b1, c0 + 37 + 5 * k);
`endif
    press(1'b1, 1'b0, 55);

    // Reset in the middle of a debounce.
    @(negedge clk);
    btn_inc = 1'b1;
    repeat (4) @(negedge clk);
    push(MINV, 1'b0, -1);
    rst = 1'b1;
    btn_inc = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    while (q.size() > 0) begin
      e = q.pop_front();
      total++;
      $display("FAIL missing_event: no output seen, expected value=%0d clip=%0b at cycle %0d", e.v, e.c, e.cyc);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
